// File: rtl/reg_wb_arbiter.sv
// reg_wb_arbiter: writeback arbiter for the register-file write port (r3_*).
// Merges ALU results (one per cycle, no backpressure) with memory results
// (valid/ready, buffered in a DEPTH-entry FIFO). ALU results always win the
// port. A starve counter raises alu_hold when the FIFO stays full too long.
// Optional feature macro: WB_MEM_BYPASS_EN. When it is defined, a memory beat
// that arrives while the FIFO is empty and no ALU beat is present goes straight
// to the output register.
//
// Handshake: a memory beat transfers on every rising edge where
// mem_valid && mem_ready. mem_ready depends only on the registered FIFO count,
// never on mem_valid. The source holds mem_addr/mem_data stable until the
// transfer. Beats to register 0 transfer but are discarded.
module reg_wb_arbiter #(
    parameter int DEPTH  = 2,
    parameter int STARVE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    input  logic [4:0]  alu_addr,
    input  logic [31:0] alu_data,
    output logic        alu_hold,
    input  logic        mem_valid,
    input  logic [4:0]  mem_addr,
    input  logic [31:0] mem_data,
    output logic        mem_ready,
    input  logic [4:0]  rd1_addr,
    input  logic [4:0]  rd2_addr,
    output logic        rd1_pending,
    output logic        rd2_pending,
    output logic [4:0]  r3_addr,
    output logic [31:0] r3_din,
    output logic        r3_wr
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [3:0]    STARVE_C = 4'(STARVE);

    logic [4:0]       fifo_addr [DEPTH];
    logic [31:0]      fifo_data [DEPTH];
    logic [DEPTH-1:0] fifo_vld;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [3:0]       starve_cnt;

    logic alu_win;
    logic mem_acc;
    logic mem_nz;
    logic fifo_full;
    logic fifo_empty;
    logic bypass;
    logic push;
    logic pop;
    logic hit1;
    logic hit2;

    assign alu_win    = alu_valid && (alu_addr != 5'd0);
    assign fifo_full  = (count == DEPTH_C);
    assign fifo_empty = (count == '0);
    assign mem_ready  = (count < DEPTH_C);
    assign mem_acc    = mem_valid && mem_ready;
    assign mem_nz     = (mem_addr != 5'd0);

`ifdef WB_MEM_BYPASS_EN
    assign bypass = mem_acc && mem_nz && fifo_empty && !alu_win;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed beat never touches the FIFO; ALU always has priority over a pop.
    assign push = mem_acc && mem_nz && !bypass;
    assign pop  = !alu_win && !fifo_empty;

    // FIFO payload storage; contents are qualified by fifo_vld, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= mem_addr;
            fifo_data[wr_ptr] <= mem_data;
        end
    end

    // FIFO pointers, occupancy count and per-slot valid bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            fifo_vld <= '0;
        end else begin
            if (push) begin
                wr_ptr           <= wr_ptr + AW'(1);
                fifo_vld[wr_ptr] <= 1'b1;
            end
            if (pop) begin
                rd_ptr           <= rd_ptr + AW'(1);
                fifo_vld[rd_ptr] <= 1'b0;
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Output register: ALU beat, then FIFO head, then bypassed memory beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            r3_wr   <= 1'b0;
            r3_addr <= 5'd0;
            r3_din  <= 32'd0;
        end else if (alu_win) begin
            r3_wr   <= 1'b1;
            r3_addr <= alu_addr;
            r3_din  <= alu_data;
        end else if (pop) begin
            r3_wr   <= 1'b1;
            r3_addr <= fifo_addr[rd_ptr];
            r3_din  <= fifo_data[rd_ptr];
        end else if (bypass) begin
            r3_wr   <= 1'b1;
            r3_addr <= mem_addr;
            r3_din  <= mem_data;
        end else begin
            r3_wr   <= 1'b0;
        end
    end

    // Starve counter: counts full-FIFO cycles lost to ALU beats, saturating.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= 4'd0;
        end else if (pop || !fifo_full) begin
            starve_cnt <= 4'd0;
        end else if (alu_win && (starve_cnt != STARVE_C)) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    // ALU hold: raised once the counter sits at STARVE, dropped once the FIFO has room.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_hold <= 1'b0;
        end else if (starve_cnt == STARVE_C) begin
            alu_hold <= 1'b1;
        end else if (!fifo_full) begin
            alu_hold <= 1'b0;
        end
    end

    // Hazard lookup: any buffered entry or the in-flight write targeting a read address.
    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (fifo_vld[i] && (fifo_addr[i] == rd1_addr)) hit1 = 1'b1;
            if (fifo_vld[i] && (fifo_addr[i] == rd2_addr)) hit2 = 1'b1;
        end
        if (r3_wr && (r3_addr == rd1_addr)) hit1 = 1'b1;
        if (r3_wr && (r3_addr == rd2_addr)) hit2 = 1'b1;
    end

    assign rd1_pending = (rd1_addr != 5'd0) && hit1;
    assign rd2_pending = (rd2_addr != 5'd0) && hit2;

endmodule
